// File: rtl/multi_cycle_control_unit.sv
// rtl/multi_cycle_control_unit.sv - Moore control FSM for the multicycle MIPS datapath
//
// Sequences FETCH/DECODE/execute steps, drives every datapath control,
// gates the PC write on Zero_i in BRANCH, counts retired instructions and
// keeps a sticky flag for unsupported encodings.
//
// Optional feature: define CU_ADDI_EN to build the addi path (ADDIEX/ADDIWB).
// Without it, opcode 001000 takes the illegal path.
//
// Ports:
//   clk            clock, all state on rising edge
//   reset          asynchronous active-low reset
//   Opcode_i       IR[31:26]
//   Funct_i        IR[5:0]
//   Zero_i         ALU zero flag, used in BRANCH
//   PCWrite, IorD, MemWrite, IRWrite, MemtoReg, RegWrite, ALUSrcA, CUS
//                  single-bit datapath controls
//   ALUSrcB        00=B, 01=const 1, 10=SignImm
//   ALUControl     0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
//   PCSrc          0=ALUResult, 1=ALUOut
//   Illegal_o      sticky unsupported-encoding flag
//   Instr_Count_o  retired-instruction counter (wraps)

module multi_cycle_control_unit #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             Opcode_i,
    input  logic [5:0]             Funct_i,
    input  logic                   Zero_i,
    output logic                   PCWrite,
    output logic                   IorD,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   ALUSrcA,
    output logic                   CUS,
    output logic [1:0]             ALUSrcB,
    output logic [3:0]             ALUControl,
    output logic                   PCSrc,
    output logic                   Illegal_o,
    output logic [COUNT_WIDTH-1:0] Instr_Count_o
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef CU_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    state_t state;
    state_t state_next;

    // lw/sw distinction captured in DECODE so MEMADR does not look at the IR
    logic mem_is_lw;

    logic pc_write_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic reg_write_raw;
    logic funct_legal;
    logic [3:0] funct_alu;
    logic decode_illegal;
    logic retire;

    always_comb begin
        funct_legal = 1'b1;
        funct_alu   = ALU_ADD;
        case (Funct_i)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            6'b100111: funct_alu = ALU_NOR;
            default:   funct_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_FETCH;
            mem_is_lw     <= 1'b0;
            Illegal_o     <= 1'b0;
            Instr_Count_o <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                mem_is_lw <= (Opcode_i == OP_LW);
            end
            if (decode_illegal) begin
                Illegal_o <= 1'b1;
            end
            if (retire) begin
                Instr_Count_o <= Instr_Count_o + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_next     = S_FETCH;
        pc_write_raw   = 1'b0;
        IorD           = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        MemtoReg       = 1'b0;
        reg_write_raw  = 1'b0;
        ALUSrcA        = 1'b0;
        CUS            = 1'b0;
        ALUSrcB        = SRCB_REG;
        ALUControl     = ALU_AND;
        PCSrc          = 1'b0;
        decode_illegal = 1'b0;
        retire         = 1'b0;

        case (state)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcA      = 1'b1;
                ALUSrcB      = SRCB_ONE;
                ALUControl   = ALU_ADD;
                pc_write_raw = 1'b1;
                state_next   = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                case (Opcode_i)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_legal) begin
                            state_next = S_EXECUTE;
                        end else begin
                            decode_illegal = 1'b1;
                        end
                    end
                    OP_BEQ: state_next = S_BRANCH;
`ifdef CU_ADDI_EN
                    OP_ADDI: state_next = S_ADDIEX;
`endif
                    default: decode_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                state_next = mem_is_lw ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                IorD       = 1'b1;
                state_next = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            S_MEMWRITE: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                retire        = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcB    = SRCB_REG;
                ALUControl = funct_alu;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                CUS           = 1'b1;
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
            S_BRANCH: begin
                ALUControl   = ALU_SUB;
                PCSrc        = 1'b1;
                pc_write_raw = Zero_i;
                retire       = 1'b1;
            end
`ifdef CU_ADDI_EN
            S_ADDIEX: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                state_next = S_ADDIWB;
            end
            S_ADDIWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                retire        = 1'b1;
            end
`endif
            default: state_next = S_FETCH;
        endcase
    end

    // While reset is held the state already reads FETCH; the write enables are
    // masked so nothing in the datapath is disturbed until release.
    assign PCWrite  = pc_write_raw  & reset;
    assign MemWrite = mem_write_raw & reset;
    assign IRWrite  = ir_write_raw  & reset;
    assign RegWrite = reg_write_raw & reset;

endmodule
